// File: rtl/seq_uart_tx.sv
// seq_uart_tx: sequencer-bus responder that queues bytes and serialises them as 8N1 UART frames.
//   Optional macro SEQ_UART_TX_PARITY_EN adds a parity bit (8E1/8O1, selected by CTRL imm[2]).
//   clock   in   rising-edge system clock
//   reset   in   asynchronous, active-low reset
//   inst    in   [11:8] opcode (0 NOP, 1 SEND, 2 FLUSH, 3 CTRL), [7:0] immediate
//   inst_en in   instruction valid
//   tx      out  UART serial line, idle high
//   status  out  [7] busy [6] full [5] empty [4] overflow [3] enabled [2:0] level (saturating)
module seq_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_AW      = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] inst,
   input  logic        inst_en,
   output logic        tx,
   output logic [7:0]  status
);
   localparam int DEPTH = 2 ** FIFO_AW;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
   state_t state, nxt;
   logic [7:0] mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0] level;
   logic [15:0] cnt;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic [31:0] lvl32;
   logic [2:0] lvl_sat;
   logic overflow, enabled, full, empty, pop, push, send, flush, ctrl, last;
   logic [3:0] op;
   logic [7:0] imm;
   assign op    = inst[11:8];
   assign imm   = inst[7:0];
   assign send  = inst_en && op == 4'd1;
   assign flush = inst_en && op == 4'd2;
   assign ctrl  = inst_en && op == 4'd3;
   assign empty = level == '0;
   assign full  = level == (FIFO_AW + 1)'(DEPTH);
   assign pop   = state == IDLE && enabled && !empty;
   // a pop in the same cycle frees the slot, so a SEND into a full FIFO still lands
   assign push  = send && (!full || pop);
   assign last  = cnt == 16'(CLKS_PER_BIT - 1);
   assign lvl32 = 32'(level);
   assign lvl_sat = lvl32 > 32'd7 ? 3'd7 : lvl32[2:0];

   always_ff @(posedge clock)
      if (push) mem[wr_ptr] <= imm;

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         enabled  <= 1'b1;
      end else begin
         wr_ptr   <= wr_ptr + FIFO_AW'(push);
         // flush discards everything behind a head that is being popped this cycle
         rd_ptr   <= flush ? wr_ptr : rd_ptr + FIFO_AW'(pop);
         level    <= flush ? '0 : level + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
         overflow <= (ctrl && imm[1]) ? 1'b0 : overflow | (send && !push);
         enabled  <= ctrl ? imm[0] : enabled;
      end

`ifdef SEQ_UART_TX_PARITY_EN
   logic odd, par;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         odd <= 1'b0;
         par <= 1'b0;
      end else begin
         odd <= ctrl ? imm[2] : odd;
         par <= pop ? ^mem[rd_ptr] ^ odd : par;
      end
`endif

   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:   nxt = pop ? START : IDLE;
         START:  nxt = last ? DATA : START;
`ifdef SEQ_UART_TX_PARITY_EN
         DATA:   nxt = (last && bit_cnt == 3'd7) ? PARITY : DATA;
         PARITY: nxt = last ? STOP : PARITY;
`else
         DATA:   nxt = (last && bit_cnt == 3'd7) ? STOP : DATA;
`endif
         STOP:   nxt = last ? IDLE : STOP;
         default: nxt = IDLE;
      endcase
   end

   // baud counter restarts on every state entry and wraps between data bits
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         cnt     <= '0;
         bit_cnt <= '0;
         shift   <= '0;
      end else begin
         cnt     <= (nxt != state || last) ? '0 : cnt + 16'd1;
         bit_cnt <= (state == DATA && last) ? bit_cnt + 3'd1 : bit_cnt;
         shift   <= pop ? mem[rd_ptr] : (state == DATA && last) ? shift >> 1 : shift;
      end

`ifdef SEQ_UART_TX_PARITY_EN
   assign tx = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par : 1'b1;
`else
   assign tx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif

   always_ff @(posedge clock or negedge reset)
      if (!reset) status <= 8'h28;
      else status <= {state != IDLE, full, empty, overflow, enabled, lvl_sat};
endmodule

// File: tb/tb_seq_uart_tx.sv
// tb_seq_uart_tx: directed self-checking bench for seq_uart_tx with CLKS_PER_BIT=4, FIFO_AW=2.
module tb_seq_uart_tx;
   localparam int CPB = 4;
`ifdef SEQ_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FR = NB * CPB;
   logic clock = 1'b0, reset = 1'b0, inst_en = 1'b0;
   logic [11:0] inst = '0;
   logic tx;
   logic [7:0] status;
   int n_cmp = 0, n_err = 0, cyc = 0;
   logic tb_odd = 1'b0;

   seq_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
      .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en), .tx(tx), .status(status)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] imm);
      @(negedge clock);
      inst = {op, imm};
      inst_en = 1'b1;
      @(posedge clock);
      #1 inst_en = 1'b0;
   endtask

   task automatic rx_byte(input string tag, input logic [7:0] exp, output int t0);
      logic [7:0] b;
      int n = 0;
      @(negedge clock);
      while (tx !== 1'b0 && n < 400) begin
         @(negedge clock);
         n++;
      end
      t0 = cyc;
      check({tag, "_start"}, tx, 0);
      if (tx !== 1'b0) return;
      repeat (2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clock);
         b[i] = tx;
      end
      check(tag, b, exp);
`ifdef SEQ_UART_TX_PARITY_EN
      repeat (CPB) @(negedge clock);
      check({tag, "_par"}, tx, ^exp ^ tb_odd);
`endif
      repeat (CPB) @(negedge clock);
      check({tag, "_stop"}, tx, 1);
   endtask

   task automatic quiet(input string tag, input int n);
      int lows = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (tx !== 1'b1) lows++;
      end
      check(tag, lows, 0);
   endtask

   function automatic logic [63:0] wave(input logic [7:0] b);
      logic [63:0] w = '0;
      for (int i = 0; i < FR; i++)
         w[i] = i < CPB ? 1'b0 : i < 9 * CPB ? b[(i - CPB) / CPB] :
                (NB == 11 && i < 10 * CPB) ? ^b ^ tb_odd : 1'b1;
      return w;
   endfunction

   initial begin
      logic [63:0] w;
      int t1, t2;
      w = '0;
      repeat (3) @(negedge clock);
      check("rst_tx", tx, 1);
      check("rst_status", status, 8'h28);
      reset = 1'b1;
      repeat (5) @(negedge clock);
      check("idle_tx", tx, 1);
      check("idle_status", status, 8'h28);

      issue(4'h0, 8'hFF);
      issue(4'h4, 8'h01);
      issue(4'hF, 8'hFF);
      quiet("ign_quiet", 20);
      check("ign_status", status, 8'h28);

      issue(4'h1, 8'hA5);
      @(negedge clock);
      check("a5_pre_tx", tx, 1);
      for (int i = 0; i < FR; i++) begin
         @(negedge clock);
         if (i == 0) check("a5_status", status, 8'h09);
         w[i] = tx;
      end
      check("a5_wave", w, wave(8'hA5));
      @(negedge clock);
      check("a5_end_tx", tx, 1);
      check("a5_tail_status", status, 8'hA8);
      @(negedge clock);
      check("a5_done_status", status, 8'h28);

      issue(4'h3, 8'h00);
      for (int k = 1; k <= 5; k++) issue(4'h1, 8'(k));
      repeat (2) @(negedge clock);
      check("ovf_status", status, 8'h54);
      quiet("ovf_disabled_quiet", 12);
      issue(4'h3, 8'h03);
      rx_byte("ovf_b1", 8'h01, t1);
      check("ovf_mid_status", status, 8'h8B);
      rx_byte("ovf_b2", 8'h02, t1);
      rx_byte("ovf_b3", 8'h03, t1);
      rx_byte("ovf_b4", 8'h04, t1);
      quiet("ovf_no_fifth", 60);
      check("ovf_end_status", status, 8'h28);

      fork
         begin
            issue(4'h3, 8'h00);
            for (int k = 0; k < 4; k++) issue(4'h1, 8'hA0 + 8'(k));
            issue(4'h3, 8'h01);
            issue(4'h1, 8'hA4);
            @(negedge clock);
            check("fp_status_full", status, 8'h4C);
            @(negedge clock);
            check("fp_status_pushpop", status, 8'hCC);
         end
         begin
            for (int k = 0; k < 5; k++) rx_byte("fp_byte", 8'hA0 + 8'(k), t1);
         end
      join
      quiet("fp_quiet", 20);

      fork
         begin
            rx_byte("b2b_00", 8'h00, t1);
            rx_byte("b2b_ff", 8'hFF, t2);
         end
         begin
            issue(4'h1, 8'h00);
            issue(4'h1, 8'hFF);
         end
      join
      check("b2b_gap", t2 - t1, FR + 1);

      fork
         rx_byte("fl_11", 8'h11, t1);
         begin
            issue(4'h1, 8'h11);
            issue(4'h1, 8'h22);
            issue(4'h1, 8'h33);
            repeat (8) @(negedge clock);
            issue(4'h2, 8'h00);
         end
      join
      quiet("fl_quiet", 60);
      check("fl_status", status, 8'h28);

`ifdef SEQ_UART_TX_PARITY_EN
      fork
         rx_byte("par_even", 8'h07, t1);
         issue(4'h1, 8'h07);
      join
      issue(4'h3, 8'h05);
      tb_odd = 1'b1;
      fork
         rx_byte("par_odd", 8'h07, t1);
         issue(4'h1, 8'h07);
      join
      quiet("par_quiet", 20);
`endif

      issue(4'h1, 8'h00);
      repeat (12) @(negedge clock);
      check("rm_pre_tx", tx, 0);
      #2 reset = 1'b0;
      #1;
      check("rm_tx", tx, 1);
      check("rm_status", status, 8'h28);
      tb_odd = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      quiet("rm_quiet", 60);
      check("rm_end_status", status, 8'h28);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/seq_uart_tx.md
Name: seq_uart_tx

Overview:
- Sequencer-bus responder: accepts 12-bit instructions from the sequencer's oreg/oreg_wen bus and serialises bytes onto an asynchronous 8N1 UART TX line.
- Transmit-side counterpart to the input devices (PushBtn) that feed the sequencer.
- Sits beside Alu/PushBtn/LedBank on one oreg_wen bit.
- status is wired back to a sequencer ireg so code can poll busy/full before issuing SEND.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit; legal range 2..65535.
- FIFO_AW, 2: FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst  in  12  instruction; [11:8] opcode, [7:0] immediate.
- inst_en  in  1  instruction valid; sampled on the rising edge of clock.
- tx  out  1  UART serial output; idle high.
- status  out  8  [7] busy, [6] full, [5] empty, [4] overflow (sticky), [3] enabled, [2:0] FIFO level (saturates at 7).

Behaviour:
- Reset (reset=0, asynchronous) drives:
  - tx=1, FIFO empty, overflow=0, enabled=1, FSM=IDLE.
  - status=8'h28.
  - All counters 0.
- Opcodes apply only when inst_en=1, one per cycle:
  - 0 NOP: no effect.
  - 1 SEND: push imm into the FIFO. If the FIFO is full, the byte is dropped and overflow is set.
  - 2 FLUSH: empty the FIFO. A frame already in progress completes.
  - 3 CTRL: imm[0] -> enabled. imm[1]=1 clears overflow.
  - 4..15: ignored, no state change.
- status is registered and reflects state one cycle after the edge that changed it.
  - The level field saturates at 7 when the FIFO holds more than 7 entries.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when compiled in).
  - IDLE: tx=1. If enabled=1 and the FIFO is not empty, pop the head into the shift register and go to START on the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit bit counter runs 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
- Back-to-back frames:
  - The FSM re-checks the FIFO in the first IDLE cycle after STOP.
  - Inter-frame gap is exactly 1 clock of tx=1 beyond the stop bit.
- busy=1 in every state except IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Reset to 0 on every state entry.
- enabled=0:
  - Prevents new pops only; the current frame finishes.
  - SEND still queues bytes.
- Simultaneous SEND and pop in the same cycle:
  - Level is unchanged.
  - Allowed even when full: the pop frees the slot, so there is no overflow.
- FLUSH in the same cycle as a pop: the pop wins for the current head; all remaining entries are cleared.
- FIFO pointers are FIFO_AW bits wide, with a separate level counter of FIFO_AW+1 bits. Pointers wrap modulo depth.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronous), with no partial-frame completion.

Optional Feature:
- Macro SEQ_UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - Parity bit = XOR of the 8 data bits (even parity), giving an 8E1 frame.
  - CTRL imm[2] selects odd parity (1) or even (0); reset value 0.
  - status[3] still reports enabled.
- Not defined: no PARITY state, frame is 8N1, imm[2] is ignored.

Test Plan:
- Reset check: with CLKS_PER_BIT=4, release reset -> tx=1, status=8'h28 and held with no inst_en.
- Single frame: SEND 8'hA5 -> first edge after inst_en=1:
  - One cycle later, status shows busy=1 or level=1; FSM starts START.
  - tx waveform: start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each 4 cycles.
  - Total 40 cycles until busy=0.
- Overflow: with enabled=0 (CTRL 8'h00), issue 5 SENDs (0x01..0x05) at FIFO_AW=2:
  - Result: status level=4, full=1, overflow=1.
  - Then CTRL 8'h03 -> overflow=0, enabled=1.
  - Bytes 0x01..0x04 transmitted in order; 0x05 never appears.
- Back-to-back: SEND 0x00 then 0xFF on consecutive cycles -> two frames separated by exactly one idle-high clock after the stop bit.
- FLUSH mid-frame: SEND 0x11, 0x22, 0x33; FLUSH during the 0x11 DATA phase:
  - 0x11 completes intact.
  - No further frames; status=8'h28 after STOP.
- Parity (macro defined): SEND 8'h07, even parity -> parity bit 1; with CTRL 8'h05 (odd parity) the parity bit is 0. The frame is 11 bits.
